misr_compactor: RTL and testbench
=================================

MISR_COMPACTOR -- requirements
Module: misr_compactor

Interface
REQ-001 Parameter WIDTH, default 8, MISR and response word width in bits (4..32).
REQ-002 Parameter POLY, default 8'h1D, Galois feedback tap mask (x^8+x^4+x^3+x^2+1).
REQ-003 Parameter SEED, default 0, MISR value loaded on reset and on start.
REQ-004 Parameter PATTERNS, default 255, number of response words compacted per session (>=1).
REQ-005 Parameter GOLDEN, default 0, expected final signature.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  session start request, sampled on each rising edge.
REQ-009 resp_valid  input  1  resp_data carries a response word this cycle.
REQ-010 resp_data  input  WIDTH  circuit-under-test response word from the pattern-generator-driven scan path.
REQ-011 busy  output  1  high while a session is compacting.
REQ-012 done  output  1  high while a result is held.
REQ-013 pass  output  1  final signature equals GOLDEN; valid only while done is high.
REQ-014 signature  output  WIDTH  current MISR contents, registered.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, CHECK, DONE.
REQ-016 IDLE: start=1 SHALL load MISR with SEED and clear the word counter, then go to RUN; otherwise hold.
REQ-017 RUN: each edge with resp_valid=1 SHALL update MISR to (MISR<<1, truncated to WIDTH) XOR (POLY if MISR[WIDTH-1]=1, else 0) XOR resp_data, and increment the counter.
REQ-018 RUN: an edge with resp_valid=0 SHALL leave MISR and counter unchanged.
REQ-019 RUN: the edge accepting word number PATTERNS SHALL apply that update and move to CHECK; further resp_valid in CHECK/DONE/IDLE SHALL be ignored.
REQ-020 CHECK: the next edge SHALL register pass = (MISR == GOLDEN) and move to DONE (done rises one cycle after the last accepted word).
REQ-021 DONE: done, pass and signature SHALL hold until start=1, which SHALL behave exactly as REQ-016 (clear done and pass, reload SEED, go to RUN).
REQ-022 start=1 while in RUN or CHECK SHALL be ignored.
REQ-023 busy SHALL be 1 exactly in RUN and CHECK; done SHALL be 1 exactly in DONE.
REQ-024 Counter width SHALL be clog2(PATTERNS+1) and SHALL never wrap within a session.
REQ-025 signature SHALL reflect the MISR register directly, with no extra pipeline stage.

Reset
REQ-026 reset=1 SHALL, on the next rising edge, force IDLE, MISR=SEED, counter=0, busy=0, done=0, pass=0, overriding start and resp_valid.
REQ-027 Reset asserted mid-session SHALL abort the session with no result; a new start is required.

Structure
REQ-028 The state enumeration and default POLY/GOLDEN constants SHALL reside in shared package bist_pkg, also usable by the pattern generator.
REQ-029 The MISR register and its next-state XOR network SHALL be a sub-module misr_core (ports: clk, reset, load, seed, enable, data_in, sig_out); the FSM and counter stay in misr_compactor.

Verification (WIDTH=8, POLY=8'h1D, SEED=0)
REQ-030 PATTERNS=2: start, then words 8'hA5, 8'h01 with resp_valid -> signature 8'hA5 then 8'h56; done=1 one cycle later; pass=1 iff GOLDEN=8'h56.
REQ-031 PATTERNS=2, GOLDEN=8'h56: words 8'hA5, 8'h00 -> signature 8'h57, done=1, pass=0.
REQ-032 resp_valid gaps: words 8'hA5, (idle 3 cycles), 8'h01 -> identical result to REQ-030; busy held high throughout.
REQ-033 Reset after first word of REQ-030 -> next edge IDLE, signature=8'h00, busy=0, done=0; subsequent resp_valid has no effect.
REQ-034 start pulsed during RUN, and resp_valid held high in DONE -> no reload, signature and pass unchanged; a second start from DONE reruns REQ-030 with the same result.
REQ-035 PATTERNS=255, resp_data all-zero from SEED=0 -> signature stays 8'h00 for 255 words, done=1, pass=1 with GOLDEN=0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: compactor FSM states and default polynomial/golden constants.
// The pattern generator uses this package as well.
package bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } misr_state_t;

   localparam logic [7:0] DEFAULT_POLY   = 8'h1D;
   localparam logic [7:0] DEFAULT_GOLDEN = 8'h00;

endpackage

// File: rtl/misr_core.sv
// Galois-style multiple-input signature register with load and enable.
// The register value goes directly to sig_out.
module misr_core #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             enable,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] sig_out
);

   logic [WIDTH-1:0] sig_r;
   logic [WIDTH-1:0] fb_s;
   logic [WIDTH-1:0] sig_nxt_s;

   // feedback taps apply only when the bit shifted out is set
   always_comb begin
      if (sig_r[WIDTH-1]) begin
         fb_s = POLY;
      end else begin
         fb_s = {WIDTH{1'b0}};
      end
      sig_nxt_s = {sig_r[WIDTH-2:0], 1'b0} ^ fb_s ^ data_in;
   end

   // signature register: reset and load take the seed, enable compacts one word
   always_ff @(posedge clk) begin
      if (reset) begin
         sig_r <= seed;
      end else if (load) begin
         sig_r <= seed;
      end else if (enable) begin
         sig_r <= sig_nxt_s;
      end else begin
         sig_r <= sig_r;
      end
   end

   assign sig_out = sig_r;

endmodule

// File: rtl/misr_compactor.sv
// Response compactor: session FSM and word counter around misr_core.
// The final signature is compared with GOLDEN.
module misr_compactor
   import bist_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEFAULT_POLY),
   parameter logic [WIDTH-1:0] SEED     = {WIDTH{1'b0}},
   parameter int               PATTERNS = 255,
   parameter logic [WIDTH-1:0] GOLDEN   = WIDTH'(DEFAULT_GOLDEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   localparam int             CW       = $clog2(PATTERNS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(PATTERNS - 1);

   misr_state_t   state_r;
   misr_state_t   state_nxt_s;
   logic [CW-1:0] cnt_r;
   logic          busy_r;
   logic          done_r;
   logic          pass_r;
   logic          busy_nxt_s;
   logic          done_nxt_s;
   logic          load_s;
   logic          enable_s;
   logic          last_s;
   logic [WIDTH-1:0] sig_s;

   assign load_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign enable_s = resp_valid && (state_r == ST_RUN);
   assign last_s   = (cnt_r == LAST_CNT);

   misr_core #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .load    (load_s),
      .seed    (SEED),
      .enable  (enable_s),
      .data_in (resp_data),
      .sig_out (sig_s)
   );

   // state register with registered busy/done flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_RUN;
            else       state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (enable_s && last_s) state_nxt_s = ST_CHECK;
            else                    state_nxt_s = ST_RUN;
         end
         ST_CHECK: state_nxt_s = ST_DONE;
         ST_DONE: begin
            if (start) state_nxt_s = ST_RUN;
            else       state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // flag decode from the upcoming state so the flags line up with state_r
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_RUN:   busy_nxt_s = 1'b1;
         ST_CHECK: busy_nxt_s = 1'b1;
         ST_DONE:  done_nxt_s = 1'b1;
         default: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
      endcase
   end

   // accepted-word counter; stops at PATTERNS because RUN is left on the last word
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CW{1'b0}};
      end else if (load_s) begin
         cnt_r <= {CW{1'b0}};
      end else if (enable_s) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // verdict captured in CHECK, held through DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         pass_r <= 1'b0;
      end else if (load_s) begin
         pass_r <= 1'b0;
      end else if (state_r == ST_CHECK) begin
         pass_r <= (sig_s == GOLDEN);
      end else begin
         pass_r <= pass_r;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign signature = sig_s;

endmodule

// File: tb/tb_misr_compactor.sv
// Bench for misr_compactor: two instances (PATTERNS=2/GOLDEN=56h and PATTERNS=255/GOLDEN=0)
// checked every cycle against a session-level model, plus hand-computed literal checks.
module tb_misr_compactor;

   logic       clk = 1'b0;
   logic       reset;
   logic       st [2];
   logic       rv [2];
   logic [7:0] rd [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic       pass_o [2];
   logic [7:0] sig_o  [2];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   misr_compactor #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .PATTERNS(2), .GOLDEN(8'h56)) dut_a (
      .clk(clk), .reset(reset), .start(st[0]), .resp_valid(rv[0]), .resp_data(rd[0]),
      .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .signature(sig_o[0]));

   misr_compactor #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .PATTERNS(255), .GOLDEN(8'h00)) dut_b (
      .clk(clk), .reset(reset), .start(st[1]), .resp_valid(rv[1]), .resp_data(rd[1]),
      .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .signature(sig_o[1]));

   // ---------------- session model ----------------
   // phase: 0 idle, 1 compacting, 2 verdict pending, 3 result held
   int  m_ph   [2];
   int  m_sig  [2];
   int  m_cnt  [2];
   bit  m_pass [2];
   int  npat   [2];
   int  gold   [2];

   initial begin
      npat[0] = 2;   gold[0] = 86;   // 8'h56
      npat[1] = 255; gold[1] = 0;
   end

   // multiply by x modulo x^8+x^4+x^3+x^2+1, then add the response word
   function automatic int misr_next(int m, int d);
      int r;
      r = (m * 2) % 256;
      if (m >= 128) r = r ^ 29;
      return r ^ d;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_ph[k] <= 0; m_sig[k] <= 0; m_cnt[k] <= 0; m_pass[k] <= 1'b0;
         end else if ((m_ph[k] == 0 || m_ph[k] == 3) && st[k]) begin
            m_ph[k] <= 1; m_sig[k] <= 0; m_cnt[k] <= 0; m_pass[k] <= 1'b0;
         end else if (m_ph[k] == 1 && rv[k]) begin
            m_sig[k] <= misr_next(m_sig[k], int'(rd[k]));
            m_cnt[k] <= m_cnt[k] + 1;
            if (m_cnt[k] + 1 == npat[k]) m_ph[k] <= 2;
         end else if (m_ph[k] == 2) begin
            m_pass[k] <= (m_sig[k] == gold[k]);
            m_ph[k]   <= 3;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("busy[%0d]", k), int'(busy_o[k]), int'(m_ph[k] == 1 || m_ph[k] == 2));
            check($sformatf("done[%0d]", k), int'(done_o[k]), int'(m_ph[k] == 3));
            check($sformatf("sig[%0d]", k), int'(sig_o[k]), m_sig[k]);
            if (m_ph[k] == 3) check($sformatf("pass[%0d]", k), int'(pass_o[k]), int'(m_pass[k]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int k, input logic s, input logic v, input logic [7:0] d);
      st[k] = s; rv[k] = v; rd[k] = d;
      @(negedge clk);
      st[k] = 1'b0; rv[k] = 1'b0; rd[k] = 8'h00;
   endtask

   task automatic result_a(input string name, input logic [7:0] sig, input logic p);
      check({name, "_sig"},  int'(sig_o[0]),  int'(sig));
      check({name, "_done"}, int'(done_o[0]), 1);
      check({name, "_pass"}, int'(pass_o[0]), int'(p));
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         st[k] = 1'b0; rv[k] = 1'b0; rd[k] = 8'h00;
      end
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_sig",  int'(sig_o[0]), 0);
      check("rst_busy", int'(busy_o[0]), 0);
      check("rst_done", int'(done_o[0]), 0);
      check("rst_pass", int'(pass_o[0]), 0);
      chk_en = 1'b1;

      // basic session A5, 01
      cyc(0, 1'b1, 1'b0, 8'h00);
      cyc(0, 1'b0, 1'b1, 8'hA5);
      check("w1_sig", int'(sig_o[0]), 8'hA5);
      cyc(0, 1'b0, 1'b1, 8'h01);
      check("w2_sig", int'(sig_o[0]), 8'h56);
      check("w2_notdone", int'(done_o[0]), 0);
      cyc(0, 1'b0, 1'b0, 8'h00);
      result_a("basic", 8'h56, 1'b1);

      // valid words in DONE ignored; restart with start pulse mid-run
      cyc(0, 1'b0, 1'b1, 8'hFF);
      cyc(0, 1'b0, 1'b1, 8'h3C);
      result_a("done_hold", 8'h56, 1'b1);
      cyc(0, 1'b1, 1'b0, 8'h00);
      cyc(0, 1'b0, 1'b1, 8'hA5);
      cyc(0, 1'b1, 1'b0, 8'h00);
      check("run_start_ign", int'(sig_o[0]), 8'hA5);
      cyc(0, 1'b0, 1'b1, 8'h01);
      cyc(0, 1'b0, 1'b0, 8'h00);
      result_a("rerun", 8'h56, 1'b1);

      // failing signature, with start during CHECK ignored
      cyc(0, 1'b1, 1'b0, 8'h00);
      cyc(0, 1'b0, 1'b1, 8'hA5);
      cyc(0, 1'b0, 1'b1, 8'h00);
      cyc(0, 1'b1, 1'b0, 8'h00);
      result_a("fail_sig", 8'h57, 1'b0);

      // gaps between valid words
      cyc(0, 1'b1, 1'b0, 8'h00);
      cyc(0, 1'b0, 1'b1, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1'b0, 1'b0, 8'h77);
         check("gap_busy", int'(busy_o[0]), 1);
      end
      cyc(0, 1'b0, 1'b1, 8'h01);
      cyc(0, 1'b0, 1'b0, 8'h00);
      result_a("gaps", 8'h56, 1'b1);

      // reset mid-session aborts
      cyc(0, 1'b1, 1'b0, 8'h00);
      cyc(0, 1'b0, 1'b1, 8'hA5);
      reset = 1'b1;
      cyc(0, 1'b0, 1'b1, 8'h01);
      reset = 1'b0;
      check("abort_sig",  int'(sig_o[0]), 0);
      check("abort_busy", int'(busy_o[0]), 0);
      check("abort_done", int'(done_o[0]), 0);
      check("abort_pass", int'(pass_o[0]), 0);
      cyc(0, 1'b0, 1'b1, 8'h01);
      cyc(0, 1'b0, 1'b1, 8'h5A);
      check("idle_sig", int'(sig_o[0]), 0);
      check("idle_busy", int'(busy_o[0]), 0);

      // 255 all-zero words on the long instance
      cyc(1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 255; i++) begin
         cyc(1, 1'b0, 1'b1, 8'h00);
         if (i == 253) check("long_busy", int'(busy_o[1]), 1);
      end
      cyc(1, 1'b0, 1'b0, 8'h00);
      check("long_sig",  int'(sig_o[1]), 0);
      check("long_done", int'(done_o[1]), 1);
      check("long_pass", int'(pass_o[1]), 1);

      // non-trivial data on the long instance, checked by the model each cycle
      cyc(1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 255; i++) begin
         cyc(1, 1'b0, 1'b1, 8'(i * 37 + 11));
         if ((i % 4) == 3) cyc(1, 1'b0, 1'b0, 8'hEE);
      end
      cyc(1, 1'b0, 1'b0, 8'h00);
      check("long2_done", int'(done_o[1]), 1);
      cyc(1, 1'b0, 1'b0, 8'h00);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
